rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8.sv | 127 ++++++++++++
 tb/tb_rr_arbiter_8.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// rr_arbiter_8
//   8-way round-robin arbiter with registered one-hot/index grant outputs and
//   an optional hold limit that preempts a long-running holder.
// Revision: 1.0
// ============================================================================
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic [7:0] req_i,
    output logic [7:0] grant_o,
    output logic [2:0] grant_idx_o,
    output logic       grant_valid_o,
    output logic       preempt_o
);

    localparam logic       c_hold_en    = (MAX_HOLD != 0);
    localparam logic [7:0] c_hold_limit = c_hold_en ? 8'(MAX_HOLD - 1) : 8'd0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] grant_q, grant_d;
    logic       preempt_q, preempt_d;

    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  win_off;
    logic [2:0]  win_idx;
    logic        others_pending;
    logic        limit_hit;

    // Rotate requests so bit 0 is the pointer position; the lowest set bit
    // of the rotated vector is the first requester in search order.
    always_comb begin
        req_dbl = {req_i, req_i};
        req_rot = req_dbl[ptr_q +: 8];
        win_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = 3'(k);
            end
        end
        win_idx = ptr_q + win_off;
    end

    assign others_pending = |(req_i & ~grant_q);
    assign limit_hit      = c_hold_en && (cnt_q >= c_hold_limit);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        preempt_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_i != 8'h00) begin
                    state_d = ST_GRANT;
                    idx_d   = win_idx;
                    grant_d = 8'd1 << win_idx;
                    ptr_d   = win_idx + 3'd1;
                    cnt_d   = 8'd0;
                end
            end
            ST_GRANT: begin
                if (req_i == 8'h00) begin
                    state_d = ST_IDLE;
                    idx_d   = 3'd0;
                    grant_d = 8'h00;
                    cnt_d   = 8'd0;
                end else if (!req_i[idx_q] || (limit_hit && others_pending)) begin
                    // Holder released or ran out its hold: hand over with no bubble.
                    idx_d     = win_idx;
                    grant_d   = 8'd1 << win_idx;
                    ptr_d     = win_idx + 3'd1;
                    cnt_d     = 8'd0;
                    preempt_d = req_i[idx_q];
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
                grant_d = 8'h00;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 3'd0;
            idx_q     <= 3'd0;
            cnt_q     <= 8'd0;
            grant_q   <= 8'h00;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_idx_o   = idx_q;
    assign grant_valid_o = (state_q == ST_GRANT);
    assign preempt_o     = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
`default_nettype none
// tb_rr_arbiter_8: vector table, directed corner sequences and a randomized
// run checked against a rule-level reference model of the arbiter.
module tb_rr_arbiter_8;

    localparam int MAXH = 4;

    logic       clk      = 1'b0;
    logic       arst_n_i = 1'b0;
    logic [7:0] req_i    = 8'h00;
    logic [7:0] grant_o;
    logic [2:0] grant_idx_o;
    logic       grant_valid_o;
    logic       preempt_o;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
        .clk_i         (clk),
        .arst_n_i      (arst_n_i),
        .req_i         (req_i),
        .grant_o       (grant_o),
        .grant_idx_o   (grant_idx_o),
        .grant_valid_o (grant_valid_o),
        .preempt_o     (preempt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [7:0] req;
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic       p;
    } vec_t;

    vec_t tbl[$];

    // Reference model state (plain integers, rule level)
    bit m_busy;
    int m_holder;
    int m_ptr;
    int m_cnt;
    bit m_pre;
    int waits[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [7:0] r, input int ptr);
        for (int k = 0; k < 8; k++) begin
            if (r[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_holder = 0; m_ptr = 0; m_cnt = 0; m_pre = 0;
        for (int n = 0; n < 8; n++) waits[n] = 0;
    endtask

    task automatic model_take(input int w);
        m_busy = 1; m_holder = w; m_ptr = (w + 1) % 8; m_cnt = 0;
    endtask

    task automatic model_step(input logic [7:0] r);
        logic [7:0] others;
        others = r & ~(8'd1 << m_holder);
        m_pre = 0;
        if (!m_busy) begin
            if (r != 8'h00) model_take(rr_pick(r, m_ptr));
        end else if (r == 8'h00) begin
            m_busy = 0; m_holder = 0; m_cnt = 0;
        end else if (!r[m_holder]) begin
            model_take(rr_pick(r, m_ptr));
        end else if (MAXH != 0 && m_cnt >= MAXH - 1 && others != 8'h00) begin
            model_take(rr_pick(r, m_ptr));
            m_pre = 1;
        end else if (m_cnt < 255) begin
            m_cnt++;
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] g, input logic [2:0] idx,
                                 input logic v, input logic p);
        chk({tag, ".grant"},   grant_o,       g);
        chk({tag, ".idx"},     grant_idx_o,   idx);
        chk({tag, ".valid"},   grant_valid_o, v);
        chk({tag, ".preempt"}, preempt_o,     p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n_i = 1'b0;
        req_i    = 8'h00;
        model_reset();
        #1;
        check_outputs("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        arst_n_i = 1'b1;
    endtask

    // One decision edge: drive at negedge, step model on posedge, compare after.
    task automatic drive_cycle(input logic [7:0] r);
        logic       pv;
        logic [2:0] pi;
        bit         newg;
        int         worst;
        logic [7:0] eg;
        @(negedge clk);
        req_i = r;
        pv = grant_valid_o;
        pi = grant_idx_o;
        @(posedge clk);
        model_step(r);
        #1;
        eg = m_busy ? (8'd1 << m_holder) : 8'h00;
        check_outputs("model", eg, m_busy ? 3'(m_holder) : 3'd0, m_busy, m_pre);
        newg = grant_valid_o && (!pv || grant_idx_o != pi);
        worst = 0;
        for (int n = 0; n < 8; n++) begin
            if (!r[n]) begin
                waits[n] = 0;
            end else if (newg) begin
                if (n == int'(grant_idx_o)) begin
                    waits[n] = 0;
                end else begin
                    waits[n]++;
                    if (waits[n] > worst) worst = waits[n];
                end
            end
        end
        if (newg) chk("fairness_turns_le_7", (worst <= 7), 1);
    endtask

    task automatic add(input bit rst, input logic [7:0] req, input logic [7:0] g,
                       input logic [2:0] idx, input logic v, input logic p);
        vec_t e;
        e.rst = rst; e.req = req; e.g = g; e.idx = idx; e.v = v; e.p = p;
        tbl.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r;

        // Single request, then idle
        add(1, 8'h20, 8'h20, 3'd5, 1, 0);
        add(0, 8'h00, 8'h00, 3'd0, 0, 0);
        // Rotation: each holder releases after one cycle
        add(1, 8'hFF, 8'h01, 3'd0, 1, 0);
        add(0, 8'hFE, 8'h02, 3'd1, 1, 0);
        add(0, 8'hFD, 8'h04, 3'd2, 1, 0);
        add(0, 8'hFB, 8'h08, 3'd3, 1, 0);
        add(0, 8'hF7, 8'h10, 3'd4, 1, 0);
        add(0, 8'hEF, 8'h20, 3'd5, 1, 0);
        add(0, 8'hDF, 8'h40, 3'd6, 1, 0);
        add(0, 8'hBF, 8'h80, 3'd7, 1, 0);
        add(0, 8'h7F, 8'h01, 3'd0, 1, 0);
        // Back-to-back handover 2 -> 6
        add(1, 8'h04, 8'h04, 3'd2, 1, 0);
        add(0, 8'h44, 8'h04, 3'd2, 1, 0);
        add(0, 8'h40, 8'h40, 3'd6, 1, 0);
        add(0, 8'h00, 8'h00, 3'd0, 0, 0);
        // Preemption with MAX_HOLD=4
        add(1, 8'h03, 8'h01, 3'd0, 1, 0);
        add(0, 8'h03, 8'h01, 3'd0, 1, 0);
        add(0, 8'h03, 8'h01, 3'd0, 1, 0);
        add(0, 8'h03, 8'h01, 3'd0, 1, 0);
        add(0, 8'h03, 8'h02, 3'd1, 1, 1);
        add(0, 8'h03, 8'h02, 3'd1, 1, 0);
        add(0, 8'h03, 8'h02, 3'd1, 1, 0);
        add(0, 8'h03, 8'h02, 3'd1, 1, 0);
        add(0, 8'h03, 8'h01, 3'd0, 1, 1);

        model_reset();
        #1;
        check_outputs("power_on_reset", 8'h00, 3'd0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            drive_cycle(tbl[i].req);
            check_outputs($sformatf("vec%0d", i), tbl[i].g, tbl[i].idx, tbl[i].v, tbl[i].p);
        end

        // Saturation: sole requester far beyond the limit, then a rival appears
        do_reset();
        for (int i = 0; i < 300; i++) drive_cycle(8'h01);
        chk("sat.holder", grant_idx_o, 3'd0);
        chk("sat.no_preempt", preempt_o, 1'b0);
        drive_cycle(8'h81);
        chk("sat.new_idx", grant_idx_o, 3'd7);
        chk("sat.preempt", preempt_o, 1'b1);
        drive_cycle(8'h81);
        chk("sat.preempt_one_cycle", preempt_o, 1'b0);

        // Asynchronous reset between clock edges during a grant
        do_reset();
        drive_cycle(8'h08);
        drive_cycle(8'h08);
        @(posedge clk);
        #3;
        arst_n_i = 1'b0;
        req_i    = 8'h00;
        #1;
        check_outputs("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        arst_n_i = 1'b1;
        drive_cycle(8'h84);
        chk("after_rst.idx", grant_idx_o, 3'd2);
        chk("after_rst.grant", grant_o, 8'h04);

        // Randomized traffic against the reference model
        do_reset();
        r = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 7))
                0:       r = 8'h00;
                1, 2:    r = 8'($urandom);
                3:       r = r & ~grant_o;
                4:       r = r | (8'd1 << $urandom_range(0, 7));
                default: r = r;
            endcase
            drive_cycle(r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
